// File: rtl/cacheline_adapter_if.sv
// cacheline_adapter_if: cache-side line port (dfp_*) and memory-side burst port (bmem_*)
// of the cache line adapter; slave is the adapter's view, master the environment's.
interface cacheline_adapter_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic [31:0]       dfp_addr;
  logic              dfp_read;
  logic              dfp_write;
  logic [LINE_W-1:0] dfp_wdata;
  logic [LINE_W-1:0] dfp_rdata;
  logic              dfp_resp;
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;
  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  dfp_rdata, dfp_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns one cache line read/write-back into a BEATS-long burst on the
// memory bus, reassembling read beats into a registered line answered with a one-cycle resp.
module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input logic clk,
  input logic rst_n,
  cacheline_adapter_if.slave bus
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [31:0] ALIGN_MASK = 32'(LINE_W / 8 - 1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, DONE} state_e;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] wbuf_q, wbuf_d, line_q, line_d;
  logic              hit, last;
  // Only beats tagged with our own burst address count; strays from other requesters are dropped
  assign hit  = bus.bmem_rvalid && bus.bmem_raddr == addr_q;
  assign last = cnt_q == CNT_W'(BEATS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.dfp_write ? WR_DATA : bus.dfp_read ? RD_REQ : IDLE;
      RD_REQ:  state_d = bus.bmem_ready ? RD_DATA : RD_REQ;
      RD_DATA: state_d = hit && last ? DONE : RD_DATA;
      WR_DATA: state_d = bus.bmem_ready && last ? DONE : WR_DATA;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    wbuf_d = wbuf_q;
    line_d = line_q;
    if (state_q == IDLE && (bus.dfp_write || bus.dfp_read)) begin
      addr_d = bus.dfp_addr & ~ALIGN_MASK;
      cnt_d  = '0;
    end
    if (state_q == IDLE && bus.dfp_write) wbuf_d = bus.dfp_wdata;
    if ((state_q == RD_DATA && hit) || (state_q == WR_DATA && bus.bmem_ready)) cnt_d = cnt_q + 1'b1;
    if (state_q == RD_DATA && hit) line_d[cnt_q*BEAT_W +: BEAT_W] = bus.bmem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      wbuf_q <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      wbuf_q <= wbuf_d;
      line_q <= line_d;
    end
  always_comb begin
    bus.dfp_resp   = state_q == DONE;
    bus.dfp_rdata  = line_q;
    bus.bmem_read  = state_q == RD_REQ;
    bus.bmem_write = state_q == WR_DATA;
    bus.bmem_addr  = addr_q;
    bus.bmem_wdata = state_q == WR_DATA ? wbuf_q[cnt_q*BEAT_W +: BEAT_W] : '0;
  end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: drives line reads/writes against a memory model and checks bursts,
// read lines and resp timing through a queue-based scoreboard.
module tb_cacheline_adapter;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cacheline_adapter_if #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus();
  cacheline_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } beat_t;
  int n_chk = 0;
  int n_fail = 0;
  beat_t exp_wr[$];
  logic [31:0] exp_rreq[$];
  logic [255:0] exp_resp[$];
  logic [255:0] last_line = '0;
  bit prev_resp = 1'b0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  // Scoreboard monitor: pops an expectation whenever the DUT presents a beat, request or resp
  always @(negedge clk) begin
    if (!rst_n) prev_resp = 1'b0;
    else begin
      if (bus.bmem_write && bus.bmem_ready) begin
        if (exp_wr.size() == 0) chk("unexpected_wr_beat", 256'(bus.bmem_write), 256'(0));
        else begin
          beat_t b;
          b = exp_wr.pop_front();
          chk("wr_beat", 256'({bus.bmem_addr, bus.bmem_wdata}), 256'({b.addr, b.data}));
        end
      end
      if (bus.bmem_write && !bus.bmem_ready && exp_wr.size() > 0)
        chk("wr_hold", 256'({bus.bmem_addr, bus.bmem_wdata}), 256'({exp_wr[0].addr, exp_wr[0].data}));
      if (bus.bmem_read && bus.bmem_ready) begin
        if (exp_rreq.size() == 0) chk("unexpected_rd_req", 256'(bus.bmem_read), 256'(0));
        else chk("rd_req_addr", 256'(bus.bmem_addr), 256'(exp_rreq.pop_front()));
      end
      if (bus.dfp_resp) begin
        chk("resp_single", 256'(prev_resp), 256'(0));
        if (exp_resp.size() == 0) chk("unexpected_resp", 256'(bus.dfp_resp), 256'(0));
        else chk("resp_rdata", bus.dfp_rdata, exp_resp.pop_front());
      end
      prev_resp = bus.dfp_resp;
    end
  end
  task automatic idle_inputs();
    bus.dfp_read = 0;
    bus.dfp_write = 0;
    bus.bmem_ready = 0;
    bus.bmem_rvalid = 0;
  endtask
  task automatic check_outputs_zero(input string name);
    chk({name, "_ctl"}, 256'({bus.dfp_resp, bus.bmem_read, bus.bmem_write, bus.bmem_addr, bus.bmem_wdata}), 256'(0));
    chk({name, "_rdata"}, bus.dfp_rdata, 256'(0));
  endtask
  // Read: memory accepts the request on the first ready cycle, then returns the line's beats
  task automatic do_read(input logic [31:0] a, input logic [255:0] line, input logic [15:0] rmask,
                         input bit noisy, input bit stray);
    logic [31:0] al;
    int acc, k, lastc, got;
    bit stray_done;
    al = a & 32'hFFFF_FFE0;
    acc = -1; k = 0; lastc = -1; got = -1; stray_done = 0;
    exp_rreq.push_back(al);
    exp_resp.push_back(line);
    last_line = line;
    for (int c = 0; c < 80 && got < 0; c++) begin
      bus.bmem_rvalid = 0;
      bus.bmem_raddr = $urandom;
      bus.bmem_rdata = {$urandom, $urandom};
      if (c == 0) begin
        bus.dfp_read = 1; bus.dfp_addr = a; bus.bmem_ready = 0;
      end else begin
        bus.dfp_addr = $urandom;
        bus.dfp_wdata = {8{$urandom}};
        bus.bmem_ready = c >= 16 || rmask[c];
        if (acc < 0) begin
          if (bus.bmem_ready) acc = c;
          if (noisy) begin bus.bmem_rvalid = 1; bus.bmem_raddr = al; end
        end else if (k < 4) begin
          if (stray && k == 1 && !stray_done) begin
            bus.bmem_rvalid = 1; bus.bmem_raddr = 32'h0000_9000; stray_done = 1;
          end else if (noisy && $urandom_range(2) == 0) begin
            bus.bmem_rvalid = 1'($urandom_range(1));
            bus.bmem_raddr = bus.bmem_rvalid ? al ^ 32'h100 : al;
          end else begin
            bus.bmem_rvalid = 1; bus.bmem_raddr = al;
            bus.bmem_rdata = line[64*k +: 64];
            k++; lastc = c;
          end
        end
      end
      @(negedge clk);
      if (bus.dfp_resp) got = c;
      @(posedge clk); #1;
    end
    chk("rd_latency", 256'(got), 256'(lastc + 1));
    idle_inputs();
  endtask
  // Write: beat i of the line goes out on the i-th ready cycle after the request is latched
  task automatic do_write(input logic [31:0] a, input logic [255:0] wd, input logic [15:0] rmask,
                          input bit also_read);
    logic [31:0] al;
    int n, e, got;
    beat_t b;
    al = a & 32'hFFFF_FFE0;
    for (int i = 0; i < 4; i++) begin
      b.addr = al; b.data = wd[64*i +: 64];
      exp_wr.push_back(b);
    end
    exp_resp.push_back(last_line);
    n = 0; e = -1; got = -1;
    for (int c = 1; c < 80 && e < 0; c++)
      if (c >= 16 || rmask[c]) begin
        n++;
        if (n == 4) e = c + 1;
      end
    for (int c = 0; c < 80 && got < 0; c++) begin
      bus.bmem_rvalid = 0;
      if (c == 0) begin
        bus.dfp_write = 1; bus.dfp_read = also_read; bus.dfp_addr = a; bus.dfp_wdata = wd;
        bus.bmem_ready = 0;
      end else begin
        bus.dfp_addr = $urandom;
        bus.dfp_wdata = {8{$urandom}};
        bus.bmem_ready = c >= 16 || rmask[c];
        bus.bmem_rvalid = 1'($urandom_range(1));
        bus.bmem_raddr = al;
        bus.bmem_rdata = {$urandom, $urandom};
      end
      @(negedge clk);
      if (bus.dfp_resp) got = c;
      @(posedge clk); #1;
    end
    chk("wr_latency", 256'(got), 256'(e));
    idle_inputs();
  endtask
  // Reset lands while beat 2 of a read is on the bus; the rest of the burst must be ignored
  task automatic reset_mid_read(input logic [31:0] a);
    logic [31:0] al;
    al = a & 32'hFFFF_FFE0;
    exp_rreq.push_back(al);
    bus.dfp_read = 1; bus.dfp_addr = a; bus.bmem_ready = 0;
    @(posedge clk); #1;
    bus.bmem_ready = 1;
    @(posedge clk); #1;
    bus.bmem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      bus.bmem_rvalid = 1; bus.bmem_raddr = al; bus.bmem_rdata = {$urandom, $urandom};
      if (k < 2) begin @(posedge clk); #1; end
    end
    #1 rst_n = 0;
    bus.dfp_read = 0;
    #1 check_outputs_zero("rst_mid_read");
    @(posedge clk); #1 rst_n = 1;
    last_line = '0;
    for (int k = 0; k < 4; k++) begin
      bus.bmem_rvalid = k < 2; bus.bmem_raddr = al; bus.bmem_rdata = {$urandom, $urandom};
      @(negedge clk);
      chk("post_rst_idle", 256'({bus.dfp_resp, bus.bmem_read, bus.bmem_write}), 256'(0));
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    logic [255:0] ln;
    bus.dfp_addr = '0; bus.dfp_wdata = '0; bus.bmem_raddr = '0; bus.bmem_rdata = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    do_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 16'hFFFF, 0, 0);
    do_write(32'h8000_0040, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 16'hFFFF, 0);
    do_write(32'h8000_0060, {8{$urandom}}, 16'hFFC7, 0);
    do_read(32'h0000_1234, {8{$urandom}}, 16'hFFFF, 0, 1);
    do_write(32'h4000_0100, {8{$urandom}}, 16'hFFFF, 1);
    reset_mid_read(32'h0000_1234);
    for (int i = 0; i < 40; i++) begin
      ln = {8{$urandom}};
      if ($urandom_range(1) == 1) do_read($urandom, ln, 16'($urandom), 1, $urandom_range(1) == 1);
      else do_write($urandom, ln, 16'($urandom), $urandom_range(1) == 1);
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    chk("queues_empty", 256'(exp_wr.size() + exp_rreq.size() + exp_resp.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
